// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states and requester identity.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        INSTR_BURST = 2'd1,
        DATA_BURST  = 2'd2
    } t_arb_state;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } t_requester;

    // Round-robin tie break: the side that did not win last time.
    function automatic t_requester rr_pick(input t_requester last_winner);
        return (last_winner == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals of the arbiter; master = arbiter view, slave = environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              i_instr_req;
    logic [ADDR_W-1:0] i_instr_addr;
    logic              o_instr_busy;
    logic              o_instr_valid;
    logic              o_instr_done;
    logic              i_data_req;
    logic              i_data_we;
    logic [ADDR_W-1:0] i_data_addr;
    logic [DATA_W-1:0] i_data_wdata;
    logic              o_data_busy;
    logic              o_data_valid;
    logic              o_data_wack;
    logic              o_data_done;
    logic [DATA_W-1:0] o_rdata;
    logic              o_mem_valid;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ready;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        input  i_instr_req, i_instr_addr, i_data_req, i_data_we, i_data_addr, i_data_wdata,
               i_mem_ready, i_mem_rdata,
        output o_instr_busy, o_instr_valid, o_instr_done, o_data_busy, o_data_valid,
               o_data_wack, o_data_done, o_rdata, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        output i_instr_req, i_instr_addr, i_data_req, i_data_we, i_data_addr, i_data_wdata,
               i_mem_ready, i_mem_rdata,
        input  o_instr_busy, o_instr_valid, o_instr_done, o_data_busy, o_data_valid,
               o_data_wack, o_data_done, o_rdata, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_burst_counter.sv
// Beat counter for one burst; wraps naturally because BURST_LEN is a power of two.
module burst_counter #(
    parameter int BURST_LEN = 16,
    localparam int CNT_W    = $clog2(BURST_LEN)
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == CNT_W'(BURST_LEN - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-refill and D-refill/write-back paths onto one burst memory port.
// Define MEM_ARB_DATA_PRIORITY_EN for fixed data-side priority on ties; otherwise round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic                i_clk,
    input  logic                i_arst,
    mem_port_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam int STEP  = DATA_W / 8;

    t_arb_state        r_state;
    t_arb_state        w_state_next;
    logic [ADDR_W-1:0] r_base_addr;
    logic              r_we;
    logic              w_grant;
    t_requester        w_grant_side;
    t_requester        w_tie_winner;
    logic              w_busy;
    logic              w_xfer;
    logic              w_last;
    logic              w_done;
    logic              w_rd_xfer;
    logic [CNT_W-1:0]  w_count;
    logic [ADDR_W-1:0] w_beat_addr;

`ifdef MEM_ARB_DATA_PRIORITY_EN
    assign w_tie_winner = REQ_DATA;
`else
    t_requester r_last_winner;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_last_winner <= REQ_INSTR;
        end else if (w_done) begin
            r_last_winner <= (r_state == DATA_BURST) ? REQ_DATA : REQ_INSTR;
        end
    end

    assign w_tie_winner = rr_pick(r_last_winner);
`endif

    assign w_busy = (r_state == INSTR_BURST) || (r_state == DATA_BURST);
    assign w_xfer = w_busy && bus.i_mem_ready;
    assign w_done = w_xfer && w_last;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_side = REQ_INSTR;
        case (r_state)
            IDLE: begin
                if (bus.i_instr_req && bus.i_data_req) begin
                    w_grant      = 1'b1;
                    w_grant_side = w_tie_winner;
                end else if (bus.i_instr_req) begin
                    w_grant      = 1'b1;
                    w_grant_side = REQ_INSTR;
                end else if (bus.i_data_req) begin
                    w_grant      = 1'b1;
                    w_grant_side = REQ_DATA;
                end
                if (w_grant) begin
                    w_state_next = (w_grant_side == REQ_DATA) ? DATA_BURST : INSTR_BURST;
                end
            end
            INSTR_BURST, DATA_BURST: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state     <= IDLE;
            r_base_addr <= '0;
            r_we        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_base_addr <= (w_grant_side == REQ_DATA) ? bus.i_data_addr : bus.i_instr_addr;
                r_we        <= (w_grant_side == REQ_DATA) && bus.i_data_we;
            end
        end
    end

    // Cleared while idle so every new burst starts at beat 0, including after an abort.
    burst_counter #(.BURST_LEN(BURST_LEN)) u_burst_counter (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_clear (w_done || !w_busy),
        .i_en    (w_xfer),
        .o_count (w_count),
        .o_last  (w_last)
    );

    assign w_beat_addr = r_base_addr + ADDR_W'(w_count) * ADDR_W'(STEP);
    assign w_rd_xfer   = w_xfer && !r_we;

    assign bus.o_instr_busy  = (r_state == INSTR_BURST);
    assign bus.o_instr_valid = (r_state == INSTR_BURST) && w_rd_xfer;
    assign bus.o_instr_done  = (r_state == INSTR_BURST) && w_done;
    assign bus.o_data_busy   = (r_state == DATA_BURST);
    assign bus.o_data_valid  = (r_state == DATA_BURST) && w_rd_xfer;
    assign bus.o_data_wack   = (r_state == DATA_BURST) && w_xfer && r_we;
    assign bus.o_data_done   = (r_state == DATA_BURST) && w_done;
    assign bus.o_rdata       = w_rd_xfer ? bus.i_mem_rdata : '0;
    assign bus.o_mem_valid   = w_busy;
    assign bus.o_mem_we      = (r_state == DATA_BURST) && r_we;
    assign bus.o_mem_addr    = w_busy ? w_beat_addr : '0;
    assign bus.o_mem_wdata   = ((r_state == DATA_BURST) && r_we) ? bus.i_data_wdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected beats, a negedge monitor checks them.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int BL = 16;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .i_clk  (clk),
        .i_arst (arst),
        .bus    (bus)
    );

    function automatic logic [31:0] mem_model(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_5A5A;
    endfunction

    assign bus.i_mem_rdata = mem_model(bus.o_mem_addr);

    typedef struct packed {
        logic        side;   // 0 = instr, 1 = data
        logic        we;
        logic [63:0] addr;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   wack_cnt = 0;
    bit   toggle_ready = 1'b0;
    int   wbeat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_burst(input logic side, input logic we, input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.side = side;
            e.we   = we;
            e.addr = base + 64'(i * 4);
            e.data = we ? (32'hD000_0000 + 32'(i)) : mem_model(base + 64'(i * 4));
            e.done = (i == BL - 1);
            sb.push_back(e);
        end
    endtask

    // Monitor: pops one expected beat per transfer seen on the requester side.
    always @(negedge clk) begin
        if (!arst && (bus.o_instr_valid || bus.o_data_valid || bus.o_data_wack)) begin
            if (bus.o_data_wack) wack_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got addr=0x%0h expected no beat", bus.o_mem_addr);
            end else begin
                mon_e = sb.pop_front();
                $display("beat side=%0d we=%0d addr=0x%0h rdata=0x%0h wdata=0x%0h",
                         (bus.o_data_valid || bus.o_data_wack), bus.o_mem_we, bus.o_mem_addr,
                         bus.o_rdata, bus.o_mem_wdata);
                chk("beat_side", 64'(bus.o_data_valid || bus.o_data_wack), 64'(mon_e.side));
                chk("beat_addr", bus.o_mem_addr, mon_e.addr);
                chk("beat_we", 64'(bus.o_mem_we), 64'(mon_e.we));
                if (mon_e.we) chk("beat_wdata", 64'(bus.o_mem_wdata), 64'(mon_e.data));
                else          chk("beat_rdata", 64'(bus.o_rdata), 64'(mon_e.data));
                chk("beat_done", 64'(mon_e.side ? bus.o_data_done : bus.o_instr_done), 64'(mon_e.done));
                if (bus.o_data_wack) chk("wack_ready", 64'(bus.i_mem_ready), 64'd1);
            end
        end else if (!arst && (bus.o_instr_done || bus.o_data_done)) begin
            total++;
            bad++;
            $display("FAIL done_without_beat: got done=1 expected 0");
        end
    end

    task automatic run_until_done(input int max_cyc, output logic gi, output logic gd);
        logic wk;
        gi = 1'b0;
        gd = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            wk = bus.o_data_wack;
            gi = bus.o_instr_done;
            gd = bus.o_data_done;
            @(posedge clk);
            #1;
            if (toggle_ready) bus.i_mem_ready = ~bus.i_mem_ready;
            if (wk) begin
                wbeat++;
                bus.i_data_wdata = 32'hD000_0000 + 32'(wbeat);
            end
            if (gi || gd) return;
        end
        total++;
        bad++;
        $display("FAIL timeout: got no done expected done within %0d cycles", max_cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic gi, gd;
        int   n, ni, nd;
        logic exp_seq [3];

        bus.i_instr_req  = 1'b0;
        bus.i_instr_addr = '0;
        bus.i_data_req   = 1'b0;
        bus.i_data_we    = 1'b0;
        bus.i_data_addr  = '0;
        bus.i_data_wdata = '0;
        bus.i_mem_ready  = 1'b1;

        // Reset state: everything quiet even though memory returns nonzero data.
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 64'(bus.o_mem_valid), 64'd0);
        chk("rst_busy", 64'({bus.o_instr_busy, bus.o_data_busy}), 64'd0);
        chk("rst_rdata", 64'(bus.o_rdata), 64'd0);
        chk("rst_mem_addr", bus.o_mem_addr, 64'd0);
        chk("rst_mem_we", 64'(bus.o_mem_we), 64'd0);
        @(posedge clk);
        #1 arst = 1'b0;

        // 1: lone I request.
        push_burst(1'b0, 1'b0, 64'h1000, BL);
        bus.i_instr_addr = 64'h1000;
        bus.i_instr_req  = 1'b1;
        @(negedge clk);
        chk("t1_busy_grant_cycle", 64'(bus.o_instr_busy), 64'd0);
        @(negedge clk);
        chk("t1_busy", 64'(bus.o_instr_busy), 64'd1);
        chk("t1_mem_valid", 64'(bus.o_mem_valid), 64'd1);
        run_until_done(100, gi, gd);
        chk("t1_done_instr", 64'(gi), 64'd1);
        bus.i_instr_req = 1'b0;
        @(negedge clk);
        chk("t1_idle_after", 64'(bus.o_mem_valid), 64'd0);

        // 2: tie right after reset, both requests held and re-arbitrated.
        @(posedge clk);
        #1 arst = 1'b1;
        @(posedge clk);
        #1 arst = 1'b0;
`ifdef MEM_ARB_DATA_PRIORITY_EN
        exp_seq = '{1'b1, 1'b1, 1'b0};
        push_burst(1'b1, 1'b0, 64'h3000, BL);
        push_burst(1'b1, 1'b0, 64'h3000, BL);
        push_burst(1'b0, 1'b0, 64'h4000, BL);
`else
        exp_seq = '{1'b1, 1'b0, 1'b1};
        push_burst(1'b1, 1'b0, 64'h3000, BL);
        push_burst(1'b0, 1'b0, 64'h4000, BL);
        push_burst(1'b1, 1'b0, 64'h3000, BL);
`endif
        bus.i_instr_addr = 64'h4000;
        bus.i_data_addr  = 64'h3000;
        bus.i_data_we    = 1'b0;
        bus.i_instr_req  = 1'b1;
        bus.i_data_req   = 1'b1;
        ni = 0;
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            run_until_done(100, gi, gd);
            chk($sformatf("t2_order_%0d", k), 64'(gd), 64'(exp_seq[k]));
            if (gd) begin
                nd++;
                if (nd == 2) bus.i_data_req = 1'b0;
            end
            if (gi) begin
                ni++;
                if (ni == 1) bus.i_instr_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t2_bubble_%0d", k), 64'({bus.o_instr_busy, bus.o_data_busy}), 64'd0);
        end

        // 3: D write-back with ready toggling.
        wbeat = 0;
        wack_cnt = 0;
        bus.i_data_wdata = 32'hD000_0000;
        bus.i_data_addr  = 64'h2000;
        bus.i_data_we    = 1'b1;
        push_burst(1'b1, 1'b1, 64'h2000, BL);
        toggle_ready     = 1'b1;
        bus.i_data_req   = 1'b1;
        run_until_done(200, gi, gd);
        chk("t3_done_data", 64'(gd), 64'd1);
        chk("t3_wack_count", 64'(wack_cnt), 64'd16);
        bus.i_data_req  = 1'b0;
        bus.i_data_we   = 1'b0;
        toggle_ready    = 1'b0;
        bus.i_mem_ready = 1'b1;

        // 4: address wrap.
        push_burst(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, BL);
        bus.i_instr_addr = 64'hFFFF_FFFF_FFFF_FFF8;
        bus.i_instr_req  = 1'b1;
        run_until_done(100, gi, gd);
        chk("t4_done_instr", 64'(gi), 64'd1);
        bus.i_instr_req = 1'b0;

        // 5: reset during beat 7 aborts; a fresh burst restarts at beat 0.
        push_burst(1'b0, 1'b0, 64'h5000, 7);
        bus.i_instr_addr = 64'h5000;
        bus.i_instr_req  = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 7; c++) begin
            @(negedge clk);
            if (bus.o_instr_valid) n++;
            @(posedge clk);
            #1;
        end
        chk("t5_beats_before_reset", 64'(n), 64'd7);
        arst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(bus.o_instr_busy), 64'd0);
        chk("t5_rst_mem_valid", 64'(bus.o_mem_valid), 64'd0);
        chk("t5_rst_valid_done", 64'({bus.o_instr_valid, bus.o_instr_done}), 64'd0);
        chk("t5_rst_addr", bus.o_mem_addr, 64'd0);
        push_burst(1'b0, 1'b0, 64'h5000, BL);
        @(posedge clk);
        #1 arst = 1'b0;
        run_until_done(100, gi, gd);
        chk("t5_done_instr", 64'(gi), 64'd1);
        bus.i_instr_req = 1'b0;

        // 6: D request dropped mid-burst; burst still completes from the latched address.
        push_burst(1'b1, 1'b0, 64'h6000, BL);
        bus.i_data_addr = 64'h6000;
        bus.i_data_we   = 1'b0;
        bus.i_data_req  = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 3; c++) begin
            @(negedge clk);
            if (bus.o_data_valid) n++;
            @(posedge clk);
            #1;
        end
        bus.i_data_req  = 1'b0;
        bus.i_data_addr = 64'hDEAD_0000;
        bus.i_data_we   = 1'b1;
        run_until_done(100, gi, gd);
        chk("t6_done_data", 64'(gd), 64'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
